pwm_seq: RTL

PWM_SEQ -- requirements
Module: pwm_seq

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_addr_step.sv | 54 +++++
 rtl/pwm_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state type and default sizing for the PWM pattern sequencer.
package pwm_pkg;

    // Default duty width; PWM period is 2^WIDTH-1 cycles.
    localparam int unsigned PWM_WIDTH_DEFAULT = 7;
    // Default number of pattern entries (power of two).
    localparam int unsigned PWM_DEPTH_DEFAULT = 32;
    // Width of the per-entry repeat counter.
    localparam int unsigned PWM_REP_W         = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } pwm_seq_state_e;

endpackage

// File: rtl/pwm_addr_step.sv
// pwm_addr_step: next pattern index (and, in ping-pong builds, next direction).
// Build option: PWM_SEQ_PINGPONG_EN selects bounce-back stepping instead of wrap.
module pwm_addr_step
    import pwm_pkg::*;
#(
    parameter  int unsigned DEPTH = PWM_DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] last_addr_i,
`ifdef PWM_SEQ_PINGPONG_EN
    input  logic          up_i,
    output logic          up_o,
`endif
    output logic [AW-1:0] addr_o
);

    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

    logic at_top;
    assign at_top = (addr_i == last_addr_i) || (addr_i == ADDR_MAX);

`ifdef PWM_SEQ_PINGPONG_EN
    // Bounce between 0 and the last entry; a single-entry sequence stays at 0.
    always_comb begin
        up_o   = up_i;
        addr_o = addr_i;
        if (last_addr_i == '0) begin
            up_o   = 1'b1;
            addr_o = '0;
        end else if (up_i) begin
            if (at_top) begin
                up_o   = 1'b0;
                addr_o = addr_i - 1'b1;
            end else begin
                addr_o = addr_i + 1'b1;
            end
        end else begin
            if (addr_i == '0) begin
                up_o   = 1'b1;
                addr_o = AW'(1);
            end else begin
                addr_o = addr_i - 1'b1;
            end
        end
    end
`else
    // Wrap to entry 0 after the last entry (or the top of memory).
    always_comb begin
        addr_o = at_top ? '0 : addr_i + 1'b1;
    end
`endif

endmodule

// File: rtl/pwm_seq.sv
// pwm_seq: plays a duty-cycle pattern from external memory, one entry per
// (repeat_i+1) PWM periods of 2^WIDTH-1 cycles each.
// Build option: PWM_SEQ_PINGPONG_EN enables ping-pong address stepping.
module pwm_seq
    import pwm_pkg::*;
#(
    parameter  int unsigned WIDTH = PWM_WIDTH_DEFAULT,
    parameter  int unsigned DEPTH = PWM_DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 programmed_i,
    input  logic                 enable_i,
    input  logic [AW-1:0]        last_addr_i,
    input  logic [PWM_REP_W-1:0] repeat_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic [AW-1:0]        addr_o,
    output logic                 pwm_o,
    output logic                 period_end_o,
    output logic                 busy_o
);

    // Last count of a period: P-1 = 2^WIDTH-2.
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);

    pwm_seq_state_e       state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [PWM_REP_W-1:0] rep_q, rep_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [AW-1:0]        step_addr;
    logic                 busy;
    logic                 period_end;
    logic                 go_idle;
`ifdef PWM_SEQ_PINGPONG_EN
    logic                 up_q, up_d;
    logic                 step_up;
`endif

    pwm_addr_step #(
        .DEPTH (DEPTH)
    ) u_step (
        .addr_i      (addr_q),
        .last_addr_i (last_addr_i),
`ifdef PWM_SEQ_PINGPONG_EN
        .up_i        (up_q),
        .up_o        (step_up),
`endif
        .addr_o      (step_addr)
    );

    assign busy       = (state_q != StIdle);
    assign period_end = busy && (cnt_q == CNT_LAST);

    // Next-state, period counter, repeat counter and address update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        addr_d  = addr_q;
`ifdef PWM_SEQ_PINGPONG_EN
        up_d    = up_q;
`endif
        go_idle = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable_i && programmed_i) begin
                    state_d = StRun;
                end
            end
            StRun, StStop: begin
                // A stop request landing on the period's last cycle needs no
                // StStop detour: the period is already complete.
                if (!programmed_i || (period_end && !enable_i)) begin
                    go_idle = 1'b1;
                end else begin
                    state_d = enable_i ? StRun : StStop;
                    if (period_end) begin
                        cnt_d = '0;
                        if (rep_q != repeat_i) begin
                            rep_d = rep_q + 1'b1;
                        end else begin
                            rep_d  = '0;
                            addr_d = step_addr;
`ifdef PWM_SEQ_PINGPONG_EN
                            up_d   = step_up;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase
        if (go_idle) begin
            state_d = StIdle;
            cnt_d   = '0;
            rep_d   = '0;
            addr_d  = '0;
`ifdef PWM_SEQ_PINGPONG_EN
            up_d    = 1'b1;
`endif
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rep_q   <= '0;
            addr_q  <= '0;
`ifdef PWM_SEQ_PINGPONG_EN
            up_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            addr_q  <= addr_d;
`ifdef PWM_SEQ_PINGPONG_EN
            up_q    <= up_d;
`endif
        end
    end

    assign busy_o       = busy;
    assign addr_o       = addr_q;
    assign period_end_o = period_end;
    assign pwm_o        = busy && programmed_i && (cnt_q < data_i);

endmodule
